// File: rtl/operand_forward_unit.sv
// operand_forward_unit: operand bypass from in-flight stages and load-use interlock
module operand_forward_unit #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int NRD = 2,
  parameter int DEPTH = 3,
  parameter int LOAD_READY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_en,
  input  logic                  flush_dec,
  input  logic                  dec_valid,
  input  logic                  dec_wr_en,
  input  logic [RA_W-1:0]       dec_rc,
  input  logic                  dec_is_load,
  input  logic                  dec_is_link,
  input  logic [NRD*RA_W-1:0]   ra,
  input  logic [NRD-1:0]        ra_used,
  input  logic [NRD*XLEN-1:0]   rd_in,
  input  logic [DEPTH*XLEN-1:0] stage_y,
  input  logic [DEPTH*XLEN-1:0] stage_pc,
  output logic [NRD*XLEN-1:0]   rd_out,
  output logic                  stall,
  output logic [31:0]           stall_cycles
);
  localparam logic [RA_W-1:0] ZERO_REG = {RA_W{1'b1}};
  logic [DEPTH-1:0] t_valid, t_load, t_link;
  logic [RA_W-1:0] t_rc [DEPTH];
  logic [NRD-1:0] req;
  logic wr_valid, ins;
  assign wr_valid = dec_valid & dec_wr_en;
  assign ins = dec_valid & ~stall & ~flush_dec;
  assign stall = |req & dec_valid & ~flush_dec;
  // Scan oldest to youngest so the youngest matching producer overrides
  always_comb begin
    rd_out = rd_in;
    req = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (t_valid[k] && t_rc[k] != ZERO_REG && t_rc[k] == ra[p*RA_W +: RA_W]) begin
          req[p] = 1'b0;
          if (t_link[k])
            rd_out[p*XLEN +: XLEN] = stage_pc[k*XLEN +: XLEN];
          else if (t_load[k] && k < LOAD_READY) begin
            rd_out[p*XLEN +: XLEN] = rd_in[p*XLEN +: XLEN];
            req[p] = ra_used[p];
          end else
            rd_out[p*XLEN +: XLEN] = stage_y[k*XLEN +: XLEN];
        end
      end
      if (ra[p*RA_W +: RA_W] == ZERO_REG) begin
        rd_out[p*XLEN +: XLEN] = '0;
        req[p] = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_valid <= '0;
      t_load <= '0;
      t_link <= '0;
      for (int k = 0; k < DEPTH; k++) t_rc[k] <= ZERO_REG;
      stall_cycles <= '0;
    end else begin
      if (pipe_en) begin
        for (int k = 1; k < DEPTH; k++) begin
          t_valid[k] <= t_valid[k-1];
          t_load[k] <= t_load[k-1];
          t_link[k] <= t_link[k-1];
          t_rc[k] <= t_rc[k-1];
        end
        t_valid[0] <= ins & wr_valid;
        t_load[0] <= ins & wr_valid & dec_is_load;
        t_link[0] <= ins & wr_valid & dec_is_link;
        t_rc[0] <= ins & wr_valid ? dec_rc : ZERO_REG;
      end
      if (stall && pipe_en && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_operand_forward_unit.sv
// tb_operand_forward_unit: directed checks of bypass priority, load-use stall, flush and reset
module tb_operand_forward_unit;
  logic clk = 1'b0;
  logic rst_n, pipe_en, flush_dec, dec_valid, dec_wr_en, dec_is_load, dec_is_link;
  logic [4:0] dec_rc;
  logic [9:0] ra;
  logic [1:0] ra_used;
  logic [63:0] rd_in, rd_out;
  logic [95:0] stage_y, stage_pc;
  logic stall;
  logic [31:0] stall_cycles;
  int total = 0, bad = 0;
  int exp_cnt = 0;
  always #5 clk = ~clk;
  operand_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush_dec(flush_dec),
    .dec_valid(dec_valid), .dec_wr_en(dec_wr_en), .dec_rc(dec_rc),
    .dec_is_load(dec_is_load), .dec_is_link(dec_is_link), .ra(ra), .ra_used(ra_used),
    .rd_in(rd_in), .stage_y(stage_y), .stage_pc(stage_pc), .rd_out(rd_out),
    .stall(stall), .stall_cycles(stall_cycles)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] rc, input logic wr, input logic ld, input logic lk);
    dec_valid = 1'b1; dec_wr_en = wr; dec_rc = rc; dec_is_load = ld; dec_is_link = lk;
    ra_used = 2'b00; flush_dec = 1'b0;
    tick();
    dec_valid = 1'b0;
  endtask
  task automatic bubble;
    dec_valid = 1'b0; ra_used = 2'b00; flush_dec = 1'b0;
    tick();
  endtask
  task automatic drain;
    for (int i = 0; i < 3; i++) bubble();
  endtask
  task automatic reader(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used);
    dec_valid = 1'b1; dec_wr_en = 1'b1; dec_rc = 5'd9; dec_is_load = 1'b0; dec_is_link = 1'b0;
    ra = {r1, r0}; ra_used = used;
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; pipe_en = 1'b1; flush_dec = 1'b0; dec_valid = 1'b0; dec_wr_en = 1'b0;
    dec_rc = 5'd0; dec_is_load = 1'b0; dec_is_link = 1'b0; ra_used = 2'b00;
    ra = {5'd31, 5'd3}; rd_in = {32'h0000_5678, 32'h0000_1234};
    stage_y = {32'hB, 32'h22, 32'hA}; stage_pc = '0;
    #12;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (rd_out[31:0] !== 32'h1234) begin bad++; $display("FAIL reset_rd0 got=%h exp=1234", rd_out[31:0]); end
    total++; if (rd_out[63:32] !== 32'h0) begin bad++; $display("FAIL reset_r31 got=%h exp=0", rd_out[63:32]); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask
  task automatic test_back_to_back;
    issue(5'd3, 1'b1, 1'b0, 1'b0);
    stage_y[31:0] = 32'h11;
    reader(5'd3, 5'd31, 2'b01);
    total++; if (rd_out[31:0] !== 32'h11) begin bad++; $display("FAIL b2b_rd0 got=%h exp=11", rd_out[31:0]); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", stall); end
  endtask
  task automatic test_priority;
    drain();
    issue(5'd3, 1'b1, 1'b0, 1'b0);
    issue(5'd8, 1'b1, 1'b0, 1'b0);
    issue(5'd3, 1'b1, 1'b0, 1'b0);
    stage_y = {32'hB, 32'h22, 32'hA};
    reader(5'd3, 5'd8, 2'b11);
    total++; if (rd_out[31:0] !== 32'hA) begin bad++; $display("FAIL prio_young got=%h exp=a", rd_out[31:0]); end
    total++; if (rd_out[63:32] !== 32'h22) begin bad++; $display("FAIL prio_mid got=%h exp=22", rd_out[63:32]); end
    drain();
    issue(5'd3, 1'b1, 1'b0, 1'b0);
    issue(5'd8, 1'b1, 1'b0, 1'b0);
    bubble();
    reader(5'd3, 5'd31, 2'b01);
    total++; if (rd_out[31:0] !== 32'hB) begin bad++; $display("FAIL prio_old got=%h exp=b", rd_out[31:0]); end
  endtask
  task automatic test_load_use;
    drain();
    stage_y = {32'hDEAD, 32'h77, 32'h99};
    issue(5'd4, 1'b1, 1'b1, 1'b0);
    reader(5'd4, 5'd31, 2'b01);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall1 got=%b exp=1", stall); end
    tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall2 got=%b exp=1", stall); end
    ra[9:5] = 5'd9; #1;
    total++; if (rd_out[63:32] !== 32'h5678) begin bad++; $display("FAIL lu_bubble got=%h exp=5678", rd_out[63:32]); end
    tick();
    exp_cnt = 2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall); end
    total++; if (rd_out[31:0] !== 32'hDEAD) begin bad++; $display("FAIL lu_data got=%h exp=dead", rd_out[31:0]); end
    total++; if (stall_cycles !== exp_cnt) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    tick();
    total++; if (rd_out[63:32] !== 32'h99) begin bad++; $display("FAIL lu_reader_in got=%h exp=99", rd_out[63:32]); end
    drain();
    issue(5'd4, 1'b1, 1'b1, 1'b0);
    reader(5'd4, 5'd31, 2'b00);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_unused got=%b exp=0", stall); end
  endtask
  task automatic test_link_r31;
    drain();
    stage_pc = {32'h0, 32'h104, 32'h0};
    stage_y = {32'h0, 32'h55, 32'h0};
    issue(5'd5, 1'b1, 1'b0, 1'b1);
    bubble();
    reader(5'd5, 5'd31, 2'b01);
    total++; if (rd_out[31:0] !== 32'h104) begin bad++; $display("FAIL link got=%h exp=104", rd_out[31:0]); end
    drain();
    issue(5'd31, 1'b1, 1'b1, 1'b0);
    reader(5'd31, 5'd31, 2'b11);
    total++; if (rd_out[31:0] !== 32'h0) begin bad++; $display("FAIL r31_data got=%h exp=0", rd_out[31:0]); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r31_stall got=%b exp=0", stall); end
  endtask
  task automatic test_store;
    drain();
    stage_y = {32'h0, 32'h0, 32'h66};
    issue(5'd6, 1'b0, 1'b0, 1'b0);
    reader(5'd6, 5'd31, 2'b01);
    total++; if (rd_out[31:0] !== 32'h1234) begin bad++; $display("FAIL store got=%h exp=1234", rd_out[31:0]); end
  endtask
  task automatic test_flush_wins;
    drain();
    issue(5'd4, 1'b1, 1'b1, 1'b0);
    reader(5'd4, 5'd31, 2'b01);
    flush_dec = 1'b1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    tick();
    flush_dec = 1'b0;
    ra[9:5] = 5'd9; #1;
    total++; if (rd_out[63:32] !== 32'h5678) begin bad++; $display("FAIL flush_bubble got=%h exp=5678", rd_out[63:32]); end
    total++; if (stall_cycles !== exp_cnt) begin bad++; $display("FAIL flush_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
  endtask
  task automatic test_freeze_reset;
    drain();
    issue(5'd4, 1'b1, 1'b1, 1'b0);
    reader(5'd4, 5'd31, 2'b01);
    pipe_en = 1'b0;
    tick(); tick(); tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL freeze_stall got=%b exp=1", stall); end
    total++; if (stall_cycles !== exp_cnt) begin bad++; $display("FAIL freeze_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    pipe_en = 1'b1;
    tick();
    exp_cnt++;
    total++; if (stall_cycles !== exp_cnt) begin bad++; $display("FAIL unfreeze_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL unfreeze_stall got=%b exp=1", stall); end
    #2 rst_n = 1'b0; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", stall); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", stall_cycles); end
    total++; if (rd_out[31:0] !== 32'h1234) begin bad++; $display("FAIL rst_mid_rd got=%h exp=1234", rd_out[31:0]); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL post_rst_stall got=%b exp=0", stall); end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_priority();
    test_load_use();
    test_link_r31();
    test_store();
    test_flush_wins();
    test_freeze_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
